// File: rtl/wb_snoop_ctrl.sv
// Snoop controller: arbitrates per-core coherence requests, broadcasts the address to
// the other enabled cores and returns one response. Optional counters: WB_SNOOP_CTRL_STATS_EN.
module wb_snoop_ctrl #(
  parameter int NUM_CORES = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  // Handshake: req_valid_i[i] is held with a stable req_adr_i slice until the one-cycle
  // rsp_valid_o[i] pulse; bus_snoop_req_o[t] is a level held until bus_snoop_ack_i[t]
  // (hit/data qualified by ack) or until the transaction times out.
  input  logic [NUM_CORES-1:0]    req_valid_i,
  input  logic [AW*NUM_CORES-1:0] req_adr_i,
  input  logic [NUM_CORES-1:0]    snoop_en_i,
  output logic [NUM_CORES-1:0]    rsp_valid_o,
  output logic                    rsp_hit_o,
  output logic [DW-1:0]           rsp_dat_o,
  output logic                    rsp_err_o,
  output logic [AW*NUM_CORES-1:0] bus_snoop_adr_o,
  output logic [NUM_CORES-1:0]    bus_snoop_req_o,
  input  logic [NUM_CORES-1:0]    bus_snoop_ack_i,
  input  logic [NUM_CORES-1:0]    bus_snoop_hit_i,
  input  logic [DW*NUM_CORES-1:0] bus_snoop_dat_i,
  output logic                    busy_o,
  output logic [1:0]              dbg_state_o
`ifdef WB_SNOOP_CTRL_STATS_EN
  ,
  output logic [31:0]             stat_snoops_o,
  output logic [31:0]             stat_hits_o,
  output logic [15:0]             stat_tmo_o
`endif
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNOOP = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         win_q, win_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic [NUM_CORES-1:0]  pend_q, pend_d;
  logic                  hit_q, hit_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic [NUM_CORES-1:0]  rsp_valid_d;
  logic                  busy_d;

  // Round-robin arbitration starting just above the last winner
  logic                  arb_found;
  logic [IW-1:0]         arb_win;
  logic [IW-1:0]         cand;
  logic [NUM_CORES-1:0]  arb_oh;
  logic [AW-1:0]         arb_adr;

  always_comb begin
    arb_found = 1'b0;
    arb_win   = rr_q;
    cand      = rr_q;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = IW'((int'(rr_q) + k) % NUM_CORES);
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
    arb_oh  = '0;
    arb_adr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_win == IW'(i)) begin
        arb_oh[i] = 1'b1;
        arb_adr   = req_adr_i[i*AW +: AW];
      end
    end
  end

  // Ack/hit evaluation against the still-pending targets only
  logic [NUM_CORES-1:0]  hitv;
  logic [NUM_CORES-1:0]  pend_clr;
  logic [DW-1:0]         first_dat;

  always_comb begin
    hitv      = pend_q & bus_snoop_ack_i & bus_snoop_hit_i;
    pend_clr  = pend_q & ~bus_snoop_ack_i;
    first_dat = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hitv[i]) first_dat = bus_snoop_dat_i[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    adr_d   = adr_q;
    pend_d  = pend_q;
    hit_d   = hit_q;
    dat_d   = dat_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          win_d   = arb_win;
          adr_d   = arb_adr;
          pend_d  = snoop_en_i & ~arb_oh;
          hit_d   = 1'b0;
          dat_d   = '0;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = ((snoop_en_i & ~arb_oh) == '0) ? S_RESP : S_SNOOP;
        end
      end
      S_SNOOP: begin
        pend_d  = pend_clr;
        timer_d = timer_q + TW'(1);
        if ((hitv != '0) && !hit_q) begin
          hit_d = 1'b1;
          dat_d = first_dat;
        end
        if (pend_clr == '0) begin
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          pend_d  = '0;
        end
      end
      S_RESP: begin
        rr_d    = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response outputs are loaded on the edge that enters RESP so they are true flops
  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if ((state_d == S_RESP) && (win_d == IW'(i))) rsp_valid_d[i] = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      rr_q        <= IW'(NUM_CORES - 1);
      adr_q       <= '0;
      pend_q      <= '0;
      hit_q       <= 1'b0;
      dat_q       <= '0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      rsp_valid_o <= '0;
      rsp_hit_o   <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rr_q        <= rr_d;
      adr_q       <= adr_d;
      pend_q      <= pend_d;
      hit_q       <= hit_d;
      dat_q       <= dat_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_hit_o   <= (state_d == S_RESP) ? hit_d : 1'b0;
      rsp_dat_o   <= (state_d == S_RESP) ? dat_d : '0;
      rsp_err_o   <= (state_d == S_RESP) ? err_d : 1'b0;
      busy_o      <= busy_d;
    end
  end

  assign bus_snoop_req_o = pend_q;
  assign bus_snoop_adr_o = {NUM_CORES{adr_q}};
  assign dbg_state_o     = state_q;

`ifdef WB_SNOOP_CTRL_STATS_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      stat_snoops_o <= '0;
      stat_hits_o   <= '0;
      stat_tmo_o    <= '0;
    end else if (state_q == S_RESP) begin
      stat_snoops_o <= stat_snoops_o + 32'd1;
      if (hit_q) stat_hits_o <= stat_hits_o + 32'd1;
      if (err_q) stat_tmo_o  <= stat_tmo_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_snoop_ctrl.sv
// Bench for wb_snoop_ctrl with four cores: directed scenarios plus a randomized
// sequence against a small reference model; responses are checked from a queue.
module tb_wb_snoop_ctrl;
  localparam int NC  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int EW  = NC + 2 + DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req_valid;
  logic [AW*NC-1:0]  req_adr;
  logic [NC-1:0]     snoop_en;
  logic [NC-1:0]     rsp_valid;
  logic              rsp_hit;
  logic [DW-1:0]     rsp_dat;
  logic              rsp_err;
  logic [AW*NC-1:0]  bus_adr;
  logic [NC-1:0]     bus_req;
  logic [NC-1:0]     bus_ack;
  logic [NC-1:0]     bus_hit;
  logic [DW*NC-1:0]  bus_dat;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef WB_SNOOP_CTRL_STATS_EN
  logic [31:0]       stat_snoops;
  logic [31:0]       stat_hits;
  logic [15:0]       stat_tmo;
`endif

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  // Clock/reset
  always #5 clk = ~clk;

  wb_snoop_ctrl #(.NUM_CORES(NC), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i        (clk),
    .wb_rst_n_i      (rst_n),
    .req_valid_i     (req_valid),
    .req_adr_i       (req_adr),
    .snoop_en_i      (snoop_en),
    .rsp_valid_o     (rsp_valid),
    .rsp_hit_o       (rsp_hit),
    .rsp_dat_o       (rsp_dat),
    .rsp_err_o       (rsp_err),
    .bus_snoop_adr_o (bus_adr),
    .bus_snoop_req_o (bus_req),
    .bus_snoop_ack_i (bus_ack),
    .bus_snoop_hit_i (bus_hit),
    .bus_snoop_dat_i (bus_dat),
    .busy_o          (busy),
    .dbg_state_o     (dbg_state)
`ifdef WB_SNOOP_CTRL_STATS_EN
    ,
    .stat_snoops_o   (stat_snoops),
    .stat_hits_o     (stat_hits),
    .stat_tmo_o      (stat_tmo)
`endif
  );

  // Scoreboard: every response pulse pops one expected {valid, hit, err, dat}
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid !== '0) begin
      logic [EW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got valid=%b, expected no response", rsp_valid);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_valid, rsp_hit, rsp_err, rsp_dat} !== e) begin
          errors++;
          $display("FAIL rsp_content: got %h, expected %h", {rsp_valid, rsp_hit, rsp_err, rsp_dat}, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_adr(input int c, input logic [AW-1:0] a);
    req_adr[c*AW +: AW] = a;
  endtask

  task automatic set_dat(input int c, input logic [DW-1:0] d);
    bus_dat[c*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_adr   = '0;
    snoop_en  = '0;
    bus_ack   = '0;
    bus_hit   = '0;
    bus_dat   = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_adr   = '0;
    snoop_en  = '0;
    bus_ack   = '0;
    bus_hit   = '0;
    bus_dat   = '0;
    repeat (2) cyc();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus_req !== '0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
    checks++; if (bus_adr !== '0) begin errors++; $display("FAIL reset_bus_adr: got %h expected 0", bus_adr); end
    checks++; if ({rsp_hit, rsp_err, rsp_dat} !== '0) begin errors++; $display("FAIL reset_rsp_fields: got %h expected 0", {rsp_hit, rsp_err, rsp_dat}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
    cyc();
  endtask

  // Cores 0 and 1 request together, twice; order must be 0,1 then 0,1
  task automatic test_arbitration();
    logic [NC-1:0] order[2];
    int n;
    snoop_en = '0;
    for (int round = 0; round < 2; round++) begin
      req_valid = 4'b0011;
      exp_q.push_back({4'b0001, 1'b0, 1'b0, 32'h0});
      exp_q.push_back({4'b0010, 1'b0, 1'b0, 32'h0});
      order[0] = '0;
      order[1] = '0;
      n = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
        cyc();
        if (rsp_valid !== '0) begin
          order[n] = rsp_valid;
          n++;
          req_valid = req_valid & ~rsp_valid;
        end
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL arb_count round %0d: got %0d responses expected 2", round, n); end
      checks++; if (order[0] !== 4'b0001) begin errors++; $display("FAIL arb_first round %0d: got %b expected 0001", round, order[0]); end
      checks++; if (order[1] !== 4'b0010) begin errors++; $display("FAIL arb_second round %0d: got %b expected 0010", round, order[1]); end
    end
    req_valid = '0;
    repeat (2) cyc();
  endtask

  task automatic test_basic();
    snoop_en = 4'b0011;
    set_adr(0, 32'h100);
    req_valid = 4'b0001;
    exp_q.push_back({4'b0001, 1'b0, 1'b0, 32'h0});
    cyc();
    checks++; if (bus_req !== 4'b0010) begin errors++; $display("FAIL basic_req_c1: got %b expected 0010", bus_req); end
    checks++; if (bus_adr[1*AW +: AW] !== 32'h100) begin errors++; $display("FAIL basic_adr_c1: got %h expected 100", bus_adr[1*AW +: AW]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %b expected 1", busy); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL basic_rsp_c1: got %b expected 0", rsp_valid); end
    bus_ack = 4'b0010;
    bus_hit = 4'b0000;
    cyc();
    bus_ack = '0;
    checks++; if (bus_req !== '0) begin errors++; $display("FAIL basic_req_c2: got %b expected 0", bus_req); end
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL basic_rsp_c2: got %b expected 0001", rsp_valid); end
    req_valid = '0;
    cyc();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c3: got %b expected 0", busy); end
    cyc();
  endtask

  task automatic test_hit_priority();
    snoop_en = 4'b1111;
    set_adr(2, 32'h2000);
    req_valid = 4'b0100;
    exp_q.push_back({4'b0100, 1'b1, 1'b0, 32'h0000AAAA});
    cyc();
    checks++; if (bus_req !== 4'b1011) begin errors++; $display("FAIL prio_req_c1: got %b expected 1011", bus_req); end
    set_dat(0, 32'hAAAA);
    set_dat(3, 32'hBBBB);
    set_dat(1, 32'hCCCC);
    bus_ack = 4'b1001;
    bus_hit = 4'b1001;
    cyc();
    checks++; if (bus_req !== 4'b0010) begin errors++; $display("FAIL prio_req_c2: got %b expected 0010", bus_req); end
    bus_ack = 4'b0010;
    bus_hit = 4'b0010;
    cyc();
    bus_ack = '0;
    bus_hit = '0;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL prio_rsp_c3: got %b expected 0100", rsp_valid); end
    checks++; if (rsp_dat !== 32'hAAAA) begin errors++; $display("FAIL prio_dat: got %h expected 0000aaaa", rsp_dat); end
    req_valid = '0;
    repeat (2) cyc();
  endtask

  task automatic test_timeout();
    int cnt;
    bit got;
    snoop_en = 4'b0011;
    set_adr(0, 32'h300);
    req_valid = 4'b0001;
    exp_q.push_back({4'b0001, 1'b0, 1'b1, 32'h0});
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc();
      if (rsp_valid !== '0) got = 1'b1;
      else if (bus_req === 4'b0010) cnt++;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_response: got none expected one within 40 cycles"); end
    checks++; if (cnt !== TMO) begin errors++; $display("FAIL tmo_req_cycles: got %0d expected %0d", cnt, TMO); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", rsp_err); end
    req_valid = '0;
    repeat (2) cyc();
  endtask

  task automatic test_no_target();
    snoop_en = 4'b0001;
    set_adr(0, 32'h440);
    req_valid = 4'b0001;
    exp_q.push_back({4'b0001, 1'b0, 1'b0, 32'h0});
    cyc();
    checks++; if (bus_req !== '0) begin errors++; $display("FAIL notgt_req: got %b expected 0", bus_req); end
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL notgt_rsp_c1: got %b expected 0001", rsp_valid); end
    req_valid = '0;
    cyc();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL notgt_pulse_width: got %b expected 0", rsp_valid); end
    cyc();
  endtask

  // Random requester/targets/acks against a reference model of one transaction
  task automatic test_back_to_back();
    int r, t;
    logic [NC-1:0] oh, pend, a, h, hv;
    logic [AW-1:0] adr;
    logic [DW-1:0] dv[NC];
    logic mh, me;
    logic [DW-1:0] md;
    bit done;
    int unsigned n_snoops, n_hits, n_tmo;
    apply_reset();
    n_snoops = 0;
    n_hits   = 0;
    n_tmo    = 0;
    for (int n = 0; n < 14; n++) begin
      r   = $urandom_range(0, NC - 1);
      oh  = NC'(1 << r);
      snoop_en = NC'($urandom_range(0, 15));
      adr = $urandom;
      set_adr(r, adr);
      req_valid = oh;
      pend = snoop_en & ~oh;
      mh = 1'b0;
      me = 1'b0;
      md = '0;
      t  = 0;
      done = (pend == '0);
      if (done) exp_q.push_back({oh, 1'b0, 1'b0, 32'h0});
      cyc();
      while (!done) begin
        checks++; if (bus_req !== pend) begin errors++; $display("FAIL rnd_req txn %0d t %0d: got %b expected %b", n, t, bus_req, pend); end
        checks++; if (bus_adr[(NC-1)*AW +: AW] !== adr) begin errors++; $display("FAIL rnd_adr txn %0d: got %h expected %h", n, bus_adr[(NC-1)*AW +: AW], adr); end
        a = ($urandom_range(0, 2) == 0) ? NC'(0) : NC'($urandom_range(0, 15));
        h = NC'($urandom_range(0, 15));
        for (int i = 0; i < NC; i++) begin
          dv[i] = $urandom;
          set_dat(i, dv[i]);
        end
        bus_ack = a;
        bus_hit = h;
        hv = pend & a & h;
        if (hv != '0 && !mh) begin
          mh = 1'b1;
          for (int i = NC - 1; i >= 0; i--) if (hv[i]) md = dv[i];
        end
        pend = pend & ~a;
        if (pend == '0) done = 1'b1;
        else if (t == TMO - 1) begin
          me = 1'b1;
          done = 1'b1;
        end
        t++;
        if (done) exp_q.push_back({oh, mh, me, md});
        cyc();
      end
      bus_ack = '0;
      bus_hit = '0;
      checks++; if (rsp_valid !== oh) begin errors++; $display("FAIL rnd_rsp txn %0d: got %b expected %b", n, rsp_valid, oh); end
      n_snoops++;
      if (mh) n_hits++;
      if (me) n_tmo++;
      req_valid = '0;
      cyc();
    end
`ifdef WB_SNOOP_CTRL_STATS_EN
    checks++; if (stat_snoops !== 32'(n_snoops)) begin errors++; $display("FAIL stat_snoops: got %0d expected %0d", stat_snoops, n_snoops); end
    checks++; if (stat_hits !== 32'(n_hits)) begin errors++; $display("FAIL stat_hits: got %0d expected %0d", stat_hits, n_hits); end
    checks++; if (stat_tmo !== 16'(n_tmo)) begin errors++; $display("FAIL stat_tmo: got %0d expected %0d", stat_tmo, n_tmo); end
`endif
  endtask

  // Async reset in SNOOP cycle 3 aborts the transaction silently
  task automatic test_reset_mid();
    snoop_en = 4'b0011;
    set_adr(0, 32'h500);
    req_valid = 4'b0001;
    repeat (3) cyc();
    checks++; if (bus_req !== 4'b0010) begin errors++; $display("FAIL rstmid_pre_req: got %b expected 0010", bus_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus_req !== '0) begin errors++; $display("FAIL rstmid_bus_req: got %b expected 0", bus_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (bus_adr !== '0) begin errors++; $display("FAIL rstmid_bus_adr: got %h expected 0", bus_adr); end
    checks++; if ({rsp_valid, rsp_hit, rsp_err, rsp_dat} !== '0) begin errors++; $display("FAIL rstmid_rsp: got %h expected 0", {rsp_valid, rsp_hit, rsp_err, rsp_dat}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", dbg_state); end
`ifdef WB_SNOOP_CTRL_STATS_EN
    checks++; if ({stat_snoops, stat_hits, stat_tmo} !== '0) begin errors++; $display("FAIL rstmid_stats: got %h expected 0", {stat_snoops, stat_hits, stat_tmo}); end
`endif
    req_valid = '0;
    repeat (2) cyc();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rstmid_no_rsp: got %b expected 0", rsp_valid); end
    rst_n = 1'b1;
    repeat (4) cyc();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_basic();
    test_hit_priority();
    test_timeout();
    test_no_target();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d outstanding responses expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
